// File: rtl/m1_muldiv_pkg.sv
// rtl/m1_muldiv_pkg.sv - shared opcodes and FSM state encoding for the M1 multiply/divide unit
package m1_muldiv_pkg;

    localparam logic MD_OP_MUL = 1'b0;
    localparam logic MD_OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/m1_muldiv_if.sv
// rtl/m1_muldiv_if.sv - pipeline-side request/result bundle of the M1 multiply/divide unit
// Purpose: groups operands, opcode, ABP handshake and results.
// Ports (slave = the unit):
//   a_i, b_i       operands (WIDTH)       op_i, signed_i   operation select
//   abp_req_i      ABP request toggle     abp_ack_o        ABP acknowledge
//   result_hi_o    MUL high / remainder   result_lo_o      MUL low / quotient
//   div0_o         divide by zero flag    busy_o           operation in progress
interface m1_muldiv_if #(
    parameter int WIDTH = 32
) ();
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             op_i;
    logic             signed_i;
    logic             abp_req_i;
    logic             abp_ack_o;
    logic [WIDTH-1:0] result_hi_o;
    logic [WIDTH-1:0] result_lo_o;
    logic             div0_o;
    logic             busy_o;

    modport slave (
        input  a_i, b_i, op_i, signed_i, abp_req_i,
        output abp_ack_o, result_hi_o, result_lo_o, div0_o, busy_o
    );

    modport master (
        output a_i, b_i, op_i, signed_i, abp_req_i,
        input  abp_ack_o, result_hi_o, result_lo_o, div0_o, busy_o
    );
endinterface

// File: rtl/m1_muldiv.sv
// rtl/m1_muldiv.sv - iterative WIDTH-bit multiply/divide unit with HI/LO result and ABP handshake
// Purpose: one shared datapath performs shift-add MUL or restoring DIV, one bit per cycle.
// Ports:
//   sys_clock_i   system clock, rising edge
//   sys_reset_i   asynchronous active-low reset
//   bus           m1_muldiv_if slave: operands, opcode, ABP req/ack, HI/LO results, div0, busy
module m1_muldiv
    import m1_muldiv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic        sys_clock_i,
    input  logic        sys_reset_i,
    m1_muldiv_if.slave  bus
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    // Two's-complement negate when en is set; used for operand magnitudes and results.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    md_state_e        state_q, state_d;
    logic             abp_last_q;
    logic [W2-1:0]    acc_q;       // MUL accumulator / DIV partial remainder
    logic [W2-1:0]    a_sh_q;      // MUL shifted multiplicand / DIV shifted divisor
    logic [WIDTH-1:0] b_sh_q;      // MUL multiplier bits / DIV quotient bits
    logic [CW-1:0]    count_q;
    logic             op_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic             div0_pend_q;

    logic             start;
    logic             b_zero;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             neg_q_d;
    logic             neg_r_d;
    logic [W2-1:0]    trial;
    logic             last_iter;
    logic [WIDTH-1:0] prod_lo;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    always_comb begin
        start   = (bus.abp_req_i != abp_last_q);
        b_zero  = (bus.b_i == '0);
        a_abs   = cond_neg(bus.a_i, bus.signed_i & bus.a_i[WIDTH-1]);
        b_abs   = cond_neg(bus.b_i, bus.signed_i & bus.b_i[WIDTH-1]);
        neg_q_d = bus.signed_i & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
        neg_r_d = bus.signed_i & bus.a_i[WIDTH-1];

        // Both operands stay below 2^(2W-1), so the MSB of the difference is its sign.
        trial = acc_q - a_sh_q;

        last_iter = (count_q == CW'(1)) ||
                    (EARLY_OUT && (op_q == MD_OP_MUL) && (b_sh_q[WIDTH-1:1] == '0));

        // 2W-bit negate done in halves: the high half borrows unless the low half is zero.
        prod_lo = cond_neg(acc_q[WIDTH-1:0], neg_q_q);
        prod_hi = cond_neg(acc_q[W2-1:WIDTH], neg_q_q)
                  - {{(WIDTH-1){1'b0}}, neg_q_q & (|acc_q[WIDTH-1:0])};
        quo     = cond_neg(b_sh_q, neg_q_q);
        rem     = cond_neg(acc_q[WIDTH-1:0], neg_r_q);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d = ((bus.op_i == MD_OP_DIV) && b_zero) ? MD_DONE : MD_CALC;
                end
            end
            MD_CALC: begin
                if (last_iter) begin
                    state_d = MD_DONE;
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge sys_clock_i or negedge sys_reset_i) begin
        if (!sys_reset_i) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge sys_clock_i or negedge sys_reset_i) begin
        if (!sys_reset_i) begin
            abp_last_q      <= 1'b0;
            acc_q           <= '0;
            a_sh_q          <= '0;
            b_sh_q          <= '0;
            count_q         <= '0;
            op_q            <= MD_OP_MUL;
            neg_q_q         <= 1'b0;
            neg_r_q         <= 1'b0;
            div0_pend_q     <= 1'b0;
            bus.abp_ack_o   <= 1'b0;
            bus.result_hi_o <= '0;
            bus.result_lo_o <= '0;
            bus.div0_o      <= 1'b0;
            bus.busy_o      <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start) begin
                        abp_last_q <= bus.abp_req_i;
                        op_q       <= bus.op_i;
                        count_q    <= CW'(WIDTH);
                        bus.busy_o <= 1'b1;
                        if (bus.op_i == MD_OP_DIV && b_zero) begin
                            // Result is preloaded so DONE emits all-ones / raw dividend.
                            acc_q       <= {{WIDTH{1'b0}}, bus.a_i};
                            a_sh_q      <= '0;
                            b_sh_q      <= '1;
                            neg_q_q     <= 1'b0;
                            neg_r_q     <= 1'b0;
                            div0_pend_q <= 1'b1;
                        end else if (bus.op_i == MD_OP_DIV) begin
                            acc_q       <= {{WIDTH{1'b0}}, a_abs};
                            a_sh_q      <= {1'b0, b_abs, {(WIDTH-1){1'b0}}};
                            b_sh_q      <= '0;
                            neg_q_q     <= neg_q_d;
                            neg_r_q     <= neg_r_d;
                            div0_pend_q <= 1'b0;
                        end else begin
                            acc_q       <= '0;
                            a_sh_q      <= {{WIDTH{1'b0}}, a_abs};
                            b_sh_q      <= b_abs;
                            neg_q_q     <= neg_q_d;
                            neg_r_q     <= 1'b0;
                            div0_pend_q <= 1'b0;
                        end
                    end
                end
                MD_CALC: begin
                    count_q <= count_q - CW'(1);
                    if (op_q == MD_OP_MUL) begin
                        if (b_sh_q[0]) begin
                            acc_q <= acc_q + a_sh_q;
                        end
                        a_sh_q <= a_sh_q << 1;
                        b_sh_q <= b_sh_q >> 1;
                    end else begin
                        if (!trial[W2-1]) begin
                            acc_q <= trial;
                        end
                        a_sh_q <= a_sh_q >> 1;
                        b_sh_q <= {b_sh_q[WIDTH-2:0], ~trial[W2-1]};
                    end
                end
                MD_DONE: begin
                    if (op_q == MD_OP_MUL) begin
                        bus.result_hi_o <= prod_hi;
                        bus.result_lo_o <= prod_lo;
                    end else begin
                        bus.result_hi_o <= rem;
                        bus.result_lo_o <= quo;
                    end
                    bus.div0_o    <= div0_pend_q;
                    bus.abp_ack_o <= bus.abp_req_i;
                    bus.busy_o    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_m1_muldiv.sv
// tb/tb_m1_muldiv.sv - directed self-checking bench for m1_muldiv
module tb_m1_muldiv;
    import m1_muldiv_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    m1_muldiv_if #(.WIDTH(32)) if_a ();
    m1_muldiv_if #(.WIDTH(32)) if_e ();
    m1_muldiv_if #(.WIDTH(8))  if_b ();

    m1_muldiv #(.WIDTH(32), .EARLY_OUT(1'b0)) dut_a (.sys_clock_i(clk), .sys_reset_i(rst_n), .bus(if_a));
    m1_muldiv #(.WIDTH(32), .EARLY_OUT(1'b1)) dut_e (.sys_clock_i(clk), .sys_reset_i(rst_n), .bus(if_e));
    m1_muldiv #(.WIDTH(8),  .EARLY_OUT(1'b0)) dut_b (.sys_clock_i(clk), .sys_reset_i(rst_n), .bus(if_b));

    function automatic logic get_ack(input int sel);
        case (sel)
            0:       return if_a.abp_ack_o;
            1:       return if_e.abp_ack_o;
            default: return if_b.abp_ack_o;
        endcase
    endfunction

    // Toggles req on the chosen unit, scrambles the operands after the sampling
    // edge, and counts edges (sampling edge included) until ack equals req.
    task automatic do_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic sgn,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output logic d0, output int cyc);
        logic req;
        bit   done;
        @(negedge clk);
        case (sel)
            0: begin
                if_a.a_i = a; if_a.b_i = b; if_a.op_i = op; if_a.signed_i = sgn;
                if_a.abp_req_i = ~if_a.abp_req_i; req = if_a.abp_req_i;
            end
            1: begin
                if_e.a_i = a; if_e.b_i = b; if_e.op_i = op; if_e.signed_i = sgn;
                if_e.abp_req_i = ~if_e.abp_req_i; req = if_e.abp_req_i;
            end
            default: begin
                if_b.a_i = a[7:0]; if_b.b_i = b[7:0]; if_b.op_i = op; if_b.signed_i = sgn;
                if_b.abp_req_i = ~if_b.abp_req_i; req = if_b.abp_req_i;
            end
        endcase
        cyc  = 0;
        done = 0;
        while (!done && cyc < 200) begin
            @(posedge clk);
            cyc++;
            #1;
            case (sel)
                0: begin if_a.a_i = $urandom; if_a.b_i = $urandom; if_a.op_i = ~op; if_a.signed_i = ~sgn; end
                1: begin if_e.a_i = $urandom; if_e.b_i = $urandom; if_e.op_i = ~op; if_e.signed_i = ~sgn; end
                default: begin if_b.a_i = 8'($urandom); if_b.b_i = 8'($urandom); if_b.op_i = ~op; if_b.signed_i = ~sgn; end
            endcase
            if (get_ack(sel) == req) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL ack_timeout unit %0d got no ack after %0d cycles, required ack==req", sel, cyc);
        end
        case (sel)
            0:       begin hi = if_a.result_hi_o; lo = if_a.result_lo_o; d0 = if_a.div0_o; end
            1:       begin hi = if_e.result_hi_o; lo = if_e.result_lo_o; d0 = if_e.div0_o; end
            default: begin hi = {24'd0, if_b.result_hi_o}; lo = {24'd0, if_b.result_lo_o}; d0 = if_b.div0_o; end
        endcase
    endtask

    task automatic test_reset();
        checks += 5;
        if (if_a.abp_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", if_a.abp_ack_o); end
        if (if_a.busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", if_a.busy_o); end
        if (if_a.div0_o !== 1'b0) begin errors++; $display("FAIL rst_div0 got %b exp 0", if_a.div0_o); end
        if (if_a.result_hi_o !== 32'd0) begin errors++; $display("FAIL rst_hi got %h exp 0", if_a.result_hi_o); end
        if (if_a.result_lo_o !== 32'd0) begin errors++; $display("FAIL rst_lo got %h exp 0", if_a.result_lo_o); end
    endtask

    task automatic test_mul();
        logic [31:0] hi, lo; logic d0; int cyc;
        do_op(0, 32'd17, 32'd3, MD_OP_MUL, 1'b0, hi, lo, d0, cyc);
        checks += 4;
        if (lo !== 32'd51) begin errors++; $display("FAIL mul_u_lo got %h exp %h", lo, 32'd51); end
        if (hi !== 32'd0) begin errors++; $display("FAIL mul_u_hi got %h exp 0", hi); end
        if (d0 !== 1'b0) begin errors++; $display("FAIL mul_u_div0 got %b exp 0", d0); end
        if (cyc != 34) begin errors++; $display("FAIL mul_u_latency got %0d exp 34", cyc); end

        do_op(0, 32'hFFFF_FFF9, 32'd3, MD_OP_MUL, 1'b1, hi, lo, d0, cyc);
        checks += 2;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mul_s got %h exp %h", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB); end
        if (cyc != 34) begin errors++; $display("FAIL mul_s_latency got %0d exp 34", cyc); end

        do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MD_OP_MUL, 1'b0, hi, lo, d0, cyc);
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL mul_max got %h exp %h", {hi, lo}, 64'hFFFF_FFFE_0000_0001); end
    endtask

    task automatic test_early_out();
        logic [31:0] hi, lo; logic d0; int cyc;
        do_op(1, 32'hFFFF_FFF9, 32'd3, MD_OP_MUL, 1'b1, hi, lo, d0, cyc);
        checks += 2;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL eo_mul got %h exp %h", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB); end
        if (cyc != 4) begin errors++; $display("FAIL eo_latency_b3 got %0d exp 4", cyc); end

        do_op(1, 32'd5, 32'd0, MD_OP_MUL, 1'b0, hi, lo, d0, cyc);
        checks += 2;
        if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL eo_mul0 got %h exp 0", {hi, lo}); end
        if (cyc != 3) begin errors++; $display("FAIL eo_latency_b0 got %0d exp 3", cyc); end

        do_op(1, 32'd2, 32'h8000_0000, MD_OP_MUL, 1'b0, hi, lo, d0, cyc);
        checks += 2;
        if ({hi, lo} !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL eo_msb got %h exp %h", {hi, lo}, 64'h0000_0001_0000_0000); end
        if (cyc != 34) begin errors++; $display("FAIL eo_latency_msb got %0d exp 34", cyc); end
    endtask

    task automatic test_div_signed();
        logic [31:0] hi, lo; logic d0; int cyc;
        do_op(0, 32'hFFFF_FFEF, 32'd5, MD_OP_DIV, 1'b1, hi, lo, d0, cyc);
        checks += 3;
        if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_n17_5_q got %h exp %h", lo, 32'hFFFF_FFFD); end
        if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL div_n17_5_r got %h exp %h", hi, 32'hFFFF_FFFE); end
        if (cyc != 34) begin errors++; $display("FAIL div_latency got %0d exp 34", cyc); end

        do_op(0, 32'd17, 32'hFFFF_FFFB, MD_OP_DIV, 1'b1, hi, lo, d0, cyc);
        checks += 2;
        if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_17_n5_q got %h exp %h", lo, 32'hFFFF_FFFD); end
        if (hi !== 32'd2) begin errors++; $display("FAIL div_17_n5_r got %h exp %h", hi, 32'd2); end

        do_op(0, 32'h8000_0000, 32'hFFFF_FFFF, MD_OP_DIV, 1'b1, hi, lo, d0, cyc);
        checks += 3;
        if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_min_q got %h exp %h", lo, 32'h8000_0000); end
        if (hi !== 32'd0) begin errors++; $display("FAIL div_min_r got %h exp 0", hi); end
        if (d0 !== 1'b0) begin errors++; $display("FAIL div_min_div0 got %b exp 0", d0); end
    endtask

    task automatic test_div_zero();
        logic [31:0] hi, lo; logic d0; int cyc;
        do_op(0, 32'd100, 32'd0, MD_OP_DIV, 1'b0, hi, lo, d0, cyc);
        checks += 4;
        if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_q got %h exp %h", lo, 32'hFFFF_FFFF); end
        if (hi !== 32'd100) begin errors++; $display("FAIL div0_r got %h exp %h", hi, 32'd100); end
        if (d0 !== 1'b1) begin errors++; $display("FAIL div0_flag got %b exp 1", d0); end
        if (cyc != 2) begin errors++; $display("FAIL div0_latency got %0d exp 2", cyc); end

        do_op(0, 32'd2, 32'd2, MD_OP_MUL, 1'b0, hi, lo, d0, cyc);
        checks += 2;
        if (lo !== 32'd4) begin errors++; $display("FAIL div0_clear_lo got %h exp 4", lo); end
        if (d0 !== 1'b0) begin errors++; $display("FAIL div0_clear got %b exp 0", d0); end
    endtask

    task automatic test_reset_mid();
        int acks, busys;
        @(negedge clk);
        if_a.a_i = 32'd9; if_a.b_i = 32'd9; if_a.op_i = MD_OP_MUL; if_a.signed_i = 1'b0;
        if_a.abp_req_i = ~if_a.abp_req_i;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (if_a.busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", if_a.busy_o); end
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (if_a.abp_ack_o !== 1'b0) begin errors++; $display("FAIL mid_rst_ack got %b exp 0", if_a.abp_ack_o); end
        if (if_a.busy_o !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", if_a.busy_o); end
        if (if_a.result_lo_o !== 32'd0) begin errors++; $display("FAIL mid_rst_lo got %h exp 0", if_a.result_lo_o); end
        if (if_a.result_hi_o !== 32'd0) begin errors++; $display("FAIL mid_rst_hi got %h exp 0", if_a.result_hi_o); end
        if_a.abp_req_i = 1'b0; if_e.abp_req_i = 1'b0; if_b.abp_req_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acks = 0; busys = 0;
        repeat (40) begin
            @(negedge clk);
            if (if_a.abp_ack_o) acks++;
            if (if_a.busy_o) busys++;
        end
        checks += 2;
        if (acks != 0) begin errors++; $display("FAIL mid_no_ack got %0d ack cycles exp 0", acks); end
        if (busys != 0) begin errors++; $display("FAIL mid_no_restart got %0d busy cycles exp 0", busys); end
    endtask

    task automatic test_back_to_back();
        int   changes;
        logic prev;
        @(negedge clk);
        if_a.a_i = 32'd6; if_a.b_i = 32'd7; if_a.op_i = MD_OP_MUL; if_a.signed_i = 1'b0;
        prev = if_a.abp_ack_o;
        if_a.abp_req_i = ~if_a.abp_req_i;
        repeat (3) @(negedge clk);
        if_a.abp_req_i = ~if_a.abp_req_i;
        @(negedge clk);
        if_a.abp_req_i = ~if_a.abp_req_i;
        changes = 0;
        repeat (100) begin
            @(negedge clk);
            if (if_a.abp_ack_o != prev) changes++;
            prev = if_a.abp_ack_o;
        end
        checks += 4;
        if (changes != 1) begin errors++; $display("FAIL dbl_toggle_completions got %0d exp 1", changes); end
        if (if_a.abp_ack_o !== if_a.abp_req_i) begin errors++; $display("FAIL dbl_toggle_ack got %b exp %b", if_a.abp_ack_o, if_a.abp_req_i); end
        if (if_a.result_lo_o !== 32'd42) begin errors++; $display("FAIL dbl_toggle_lo got %h exp %h", if_a.result_lo_o, 32'd42); end
        if (if_a.busy_o !== 1'b0) begin errors++; $display("FAIL dbl_toggle_busy got %b exp 0", if_a.busy_o); end
    endtask

    task automatic test_width8();
        logic [31:0] hi, lo; logic d0; int cyc;
        do_op(2, 32'hFF, 32'h10, MD_OP_DIV, 1'b0, hi, lo, d0, cyc);
        checks += 3;
        if (lo !== 32'd15) begin errors++; $display("FAIL w8_div_q got %h exp %h", lo, 32'd15); end
        if (hi !== 32'd15) begin errors++; $display("FAIL w8_div_r got %h exp %h", hi, 32'd15); end
        if (cyc != 10) begin errors++; $display("FAIL w8_div_latency got %0d exp 10", cyc); end

        do_op(2, 32'hFF, 32'hFF, MD_OP_MUL, 1'b0, hi, lo, d0, cyc);
        checks += 3;
        if (hi !== 32'hFE) begin errors++; $display("FAIL w8_mul_hi got %h exp %h", hi, 32'hFE); end
        if (lo !== 32'h01) begin errors++; $display("FAIL w8_mul_lo got %h exp %h", lo, 32'h01); end
        if (cyc != 10) begin errors++; $display("FAIL w8_mul_latency got %0d exp 10", cyc); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        if_a.a_i = '0; if_a.b_i = '0; if_a.op_i = 1'b0; if_a.signed_i = 1'b0; if_a.abp_req_i = 1'b0;
        if_e.a_i = '0; if_e.b_i = '0; if_e.op_i = 1'b0; if_e.signed_i = 1'b0; if_e.abp_req_i = 1'b0;
        if_b.a_i = '0; if_b.b_i = '0; if_b.op_i = 1'b0; if_b.signed_i = 1'b0; if_b.abp_req_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_mul();
        test_early_out();
        test_div_signed();
        test_div_zero();
        test_reset_mid();
        test_back_to_back();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
